// File: rtl/rr_multiplexer.sv
// N-channel registered merge point: per-channel valid/ready inputs, one-entry
// output register, round-robin (MODE 0) or fixed-priority (MODE 1) arbitration.
module rr_multiplexer #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // Handshake rule on both sides: a transfer happens on a rising edge where
  // valid and ready are both high; valid never waits on ready.

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant_sel;
  logic [SEL_W-1:0] next_ptr;
  logic [WIDTH-1:0] grant_data;
  logic             found;
  logic             can_load;
  logic             take;

  assign can_load = !out_valid || out_ready;
  assign take     = found && can_load;

  // Search from rr_ptr upward with wrap; fixed priority searches from 0.
  always_comb begin
    int idx;
    idx       = 0;
    found     = 1'b0;
    grant_sel = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = (MODE == 1) ? k : int'(rr_ptr) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!found && in_valid[idx[SEL_W-1:0]]) begin
        found     = 1'b1;
        grant_sel = idx[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_sel == SEL_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Gated with reset_n so no accept is advertised while reset is held.
  always_comb begin
    in_ready = '0;
    if (take && reset_n) in_ready[grant_sel] = 1'b1;
  end

  assign next_ptr = (grant_sel == SEL_W'(CHANNELS - 1)) ? '0 : grant_sel + SEL_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else begin
      if (take) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant_sel;
        if (MODE == 0) rr_ptr <= next_ptr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_multiplexer.sv
// Bench for rr_multiplexer: a round-robin and a fixed-priority instance share
// stimulus; a reference model predicts grants, a monitor checks the outputs.
module tb_rr_multiplexer;

  localparam int W = 32;
  localparam int C = 4;
  localparam int S = 2;

  logic           clock;
  logic           reset_n;
  logic [C*W-1:0] in_data;
  logic [C-1:0]   in_valid;
  logic           out_ready;

  logic [C-1:0]   in_ready0, in_ready1;
  logic [W-1:0]   out_data0, out_data1;
  logic [S-1:0]   out_sel0, out_sel1;
  logic           out_valid0, out_valid1;

  rr_multiplexer #(.WIDTH(W), .CHANNELS(C), .MODE(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .out_data(out_data0), .out_sel(out_sel0),
    .out_valid(out_valid0), .out_ready(out_ready)
  );

  rr_multiplexer #(.WIDTH(W), .CHANNELS(C), .MODE(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .out_data(out_data1), .out_sel(out_sel1),
    .out_valid(out_valid1), .out_ready(out_ready)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // expected {sel, data} per accepted transfer, one queue per instance
  logic [S+W-1:0] exp_q0[$];
  logic [S+W-1:0] exp_q1[$];

  // reference model state: is the output holding something, and whose turn
  bit m_full[2];
  int m_ptr[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int mode, input int ptr, input logic [C-1:0] v);
    for (int k = 0; k < C; k++) begin
      int idx;
      idx = (mode == 1) ? k : (ptr + k) % C;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [C*W-1:0] rand_data();
    logic [C*W-1:0] d;
    for (int i = 0; i < C; i++) d[i*W +: W] = $urandom;
    return d;
  endfunction

  function automatic logic [C*W-1:0] fill_data(input logic [W-1:0] base);
    logic [C*W-1:0] d;
    for (int i = 0; i < C; i++) d[i*W +: W] = base + W'(i);
    return d;
  endfunction

  // driver: one clock cycle of stimulus, checks combinational ready and the
  // output valid against the model, then advances the model at the edge
  task automatic step(input logic [C-1:0] v, input logic [C*W-1:0] d, input logic ordy);
    int g[2];
    bit load[2];
    logic [C-1:0] exp_rdy;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #2;
    for (int m = 0; m < 2; m++) begin
      g[m]    = pick(m, m_ptr[m], v);
      load[m] = (g[m] >= 0) && (!m_full[m] || ordy);
      exp_rdy = load[m] ? (C'(1) << g[m]) : '0;
      if (m == 0) begin
        chk("rr_in_ready", 64'(in_ready0), 64'(exp_rdy));
        chk("rr_out_valid", 64'(out_valid0), 64'(m_full[0]));
      end else begin
        chk("fp_in_ready", 64'(in_ready1), 64'(exp_rdy));
        chk("fp_out_valid", 64'(out_valid1), 64'(m_full[1]));
      end
    end
    @(posedge clock);
    for (int m = 0; m < 2; m++) begin
      if (load[m]) begin
        if (m == 0) begin
          exp_q0.push_back({S'(g[m]), d[g[m]*W +: W]});
          m_ptr[0] = (g[m] + 1) % C;
        end else begin
          exp_q1.push_back({S'(g[m]), d[g[m]*W +: W]});
        end
        m_full[m] = 1'b1;
      end else if (ordy) begin
        m_full[m] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    for (int m = 0; m < 2; m++) begin
      m_full[m] = 1'b0;
      m_ptr[m]  = 0;
    end
  endtask

  // monitor: whatever is on the output must match the queue head; the head
  // retires only when the output handshake completes
  always @(negedge clock) begin
    if (reset_n) begin
      if (out_valid0) begin
        if (exp_q0.size() == 0) chk("rr_unexpected_out", 64'(out_sel0), 64'hFFFF);
        else begin
          chk("rr_out", 64'({out_sel0, out_data0}), 64'(exp_q0[0]));
          if (out_ready) void'(exp_q0.pop_front());
        end
      end
      if (out_valid1) begin
        if (exp_q1.size() == 0) chk("fp_unexpected_out", 64'(out_sel1), 64'hFFFF);
        else begin
          chk("fp_out", 64'({out_sel1, out_data1}), 64'(exp_q1[0]));
          if (out_ready) void'(exp_q1.pop_front());
        end
      end
    end
  end

  initial begin
    model_reset();
    reset_n   = 1'b0;
    in_valid  = 4'b1111;
    in_data   = fill_data(32'hA0);
    out_ready = 1'b0;
    #2;
    chk("reset_in_ready_rr", 64'(in_ready0), 64'h0);
    chk("reset_in_ready_fp", 64'(in_ready1), 64'h0);
    chk("reset_out_valid_rr", 64'(out_valid0), 64'h0);
    chk("reset_out_sel_rr", 64'(out_sel0), 64'h0);
    chk("reset_out_data_rr", 64'(out_data0), 64'h0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // all valid, drain every cycle: round-robin 0,1,2,3,0
    for (int i = 0; i < 5; i++) step(4'b1111, fill_data(32'hA0), 1'b1);

    // skip and wrap: pointer is now 1; move it to 2, then 1010
    step(4'b0010, fill_data(32'hB0), 1'b1);
    for (int i = 0; i < 2; i++) step(4'b1010, fill_data(32'hC0), 1'b1);

    // backpressure: DEAD from channel 2, then stall 5 cycles with all valid
    step(4'b0000, fill_data(32'h0), 1'b1);
    step(4'b0100, {32'h0, 32'hDEAD, 32'h0, 32'h0}, 1'b1);
    for (int i = 0; i < 5; i++) step(4'b1111, fill_data(32'hE0), 1'b0);
    step(4'b1111, fill_data(32'hE0), 1'b1);

    // fixed priority: 1100 twice then 1110
    step(4'b1100, fill_data(32'h10), 1'b1);
    step(4'b1100, fill_data(32'h20), 1'b1);
    step(4'b1110, fill_data(32'h30), 1'b1);

    // randomized traffic with random backpressure
    for (int i = 0; i < 300; i++)
      step(C'($urandom_range(0, 15)), rand_data(), $urandom_range(0, 3) != 0);

    // async reset between edges while the output holds a transfer
    step(4'b1111, rand_data(), 1'b0);
    chk("pre_reset_valid_rr", 64'(out_valid0), 64'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_valid_rr", 64'(out_valid0), 64'h0);
    chk("async_reset_valid_fp", 64'(out_valid1), 64'h0);
    chk("async_reset_ready_rr", 64'(in_ready0), 64'h0);
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;

    // after reset the round-robin pointer restarts at channel 0
    for (int i = 0; i < 3; i++) step(4'b1111, fill_data(32'hF0), 1'b1);
    for (int i = 0; i < 100; i++)
      step(C'($urandom_range(0, 15)), rand_data(), $urandom_range(0, 1) != 0);

    for (int i = 0; i < 3; i++) step(4'b0000, rand_data(), 1'b1);
    #5;
    chk("rr_queue_drained", 64'(exp_q0.size()), 64'h0);
    chk("fp_queue_drained", 64'(exp_q1.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
